ex_hilo_div: RTL and testbench
==============================

// Module: ex_hilo_div
// PURPOSE
//   EX-stage HI/LO unit, downstream of ID. Consumes forwarded operands (ndata1/ndata2) for DIV/DIVU
//   and, optionally, MULT/MULTU. Runs a radix-2 restoring divider, one quotient bit per cycle.
//   Holds the architectural HI/LO registers and raises a stall request while busy.
//   MFHI/MFLO read hi_o/lo_o; MTHI/MTLO write through a direct port.
// PARAMETERS
//   WIDTH      32   operand/result width; the iteration count equals WIDTH
// PORTS
//   clk           in   1      clock
//   rst           in   1      synchronous active-high reset
//   div_start_i   in   1      one-cycle request: begin DIV/DIVU with opa_i/opb_i
//   mul_start_i   in   1      one-cycle request: begin MULT/MULTU (see CONFIGURATION)
//   signed_i      in   1      1 = signed (DIV/MULT), 0 = unsigned; sampled with start
//   opa_i         in   WIDTH  dividend / multiplicand (rs value)
//   opb_i         in   WIDTH  divisor / multiplier (rt value)
//   annul_i       in   1      cancel the in-flight operation; no HI/LO update
//   hi_we_i       in   1      MTHI write enable
//   lo_we_i       in   1      MTLO write enable
//   hilo_wdata_i  in   WIDTH  MTHI/MTLO data
//   stallreq_o    out  1      request stall of ID/EX (to the stall controller)
//   ready_o       out  1      one-cycle pulse: HI/LO were updated at this edge
//   hi_o          out  WIDTH  HI register (remainder / product high)
//   lo_o          out  WIDTH  LO register (quotient / product low)
// BEHAVIOUR
// - Reset: state=IDLE; hi_o=lo_o=0; stallreq_o=0; ready_o=0; internal counter and shift registers cleared.
// - FSM states: IDLE, DIV_ZERO, BUSY, MUL (MUL only with macro), DONE.
// - IDLE + div_start_i:
//     - Latch |opa| and |opb| (absolute values when signed_i=1), the sign flags and signed_i.
//     - Go to DIV_ZERO if opb_i==0, else go to BUSY with count=0.
// - BUSY: each cycle shift {rem,quo} left by 1.
//     - Trial-subtract the divisor from rem; if no borrow, keep the difference and set the quotient LSB.
//     - Increment count; after WIDTH iterations (count==WIDTH-1) go to DONE.
// - DIV_ZERO: go to DONE next cycle with quotient=0 and remainder=opa_i as latched (raw, not absolute).
// - DONE: for one cycle, ready_o=1, LO<=quotient and HI<=remainder, then go to IDLE.
//     - Signed fix-up: negate the quotient if the operand signs differ.
//     - Signed fix-up: the remainder takes the dividend's sign.
//     - 0x80000000 / -1 (signed) gives LO=0x80000000, HI=0; this wraps and is not trapped.
// - Latency: start at edge T; divide ready_o at T+WIDTH+1; divide-by-zero ready_o at T+2.
// - stallreq_o = (IDLE & (div_start_i|mul_start_i)) | BUSY | DIV_ZERO | MUL.
//     - stallreq_o is 0 in DONE so the issuing instruction leaves EX on the ready_o cycle.
// - Starts are ignored unless state==IDLE. If both starts are asserted, div_start_i wins.
// - annul_i in any non-IDLE state: go to IDLE next edge, no HI/LO write, no ready_o.
//     - annul_i in IDLE is ignored; annul_i wins over a same-cycle start.
// - MTHI/MTLO:
//     - In IDLE, hi_we_i/lo_we_i write hilo_wdata_i at the edge.
//     - In DONE, the divider/multiplier result wins over a same-cycle direct write.
//     - In other states, direct writes are dropped.
// - rst mid-operation aborts immediately to reset values.
// CONFIGURATION
// - EX_HILO_MUL_EN defined:
//     - IDLE + mul_start_i latches the operands and goes to MUL.
//     - MUL computes the 2*WIDTH signed/unsigned product, then goes to DONE.
//     - DONE writes {HI,LO}=product and pulses ready_o. Start-to-ready latency is 2 cycles.
// - EX_HILO_MUL_EN undefined:
//     - mul_start_i is ignored, with no stall and no state change. The port remains present.
// TESTING
// - Unsigned 100/7: div_start_i, signed_i=0 -> ready_o at T+33; LO=14, HI=2; stallreq_o high T..T+32.
// - Signed -7/2 (0xFFFFFFF9/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; signed 7/-2 -> LO=0xFFFFFFFD, HI=1.
// - Divide by zero 5/0 -> ready_o at T+2; LO=0, HI=5; 0x80000000/-1 signed -> LO=0x80000000, HI=0.
// - Annul: start 100/7, annul_i at T+10 -> IDLE at T+11, stallreq_o=0, HI/LO keep their prior values;
//   a new start at T+12 completes normally.
// - MTHI 0x1234 in IDLE -> hi_o=0x1234 next cycle; hi_we_i during BUSY -> no change;
//   rst during BUSY -> hi_o=lo_o=0, no ready_o.
// - EX_HILO_MUL_EN: MULT 0xFFFFFFFF*2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same -> HI=1, LO=0xFFFFFFFE;
//   ready_o at T+2. Without the macro -> no ready_o, no stall.

Source files
------------

// File: rtl/ex_hilo_div.sv
// ex_hilo_div: EX-stage HI/LO unit with a radix-2 restoring divider.
//
// Holds the architectural HI/LO registers. DIV/DIVU run one quotient bit per cycle
// and raise stallreq_o while in flight. MTHI/MTLO write directly while idle.
// Optional MULT/MULTU support is compiled in when EX_HILO_MUL_EN is defined.
// Without it, mul_start_i is accepted but ignored.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   div_start_i     one-cycle DIV/DIVU request (operands opa_i / opb_i)
//   mul_start_i     one-cycle MULT/MULTU request (only with EX_HILO_MUL_EN)
//   signed_i        1 = signed operation, sampled with the start
//   opa_i, opb_i    dividend/multiplicand, divisor/multiplier
//   annul_i         cancel an in-flight operation (no HI/LO write)
//   hi_we_i/lo_we_i MTHI/MTLO write enables, data on hilo_wdata_i
//   stallreq_o      stall request to the ID/EX stall controller
//   ready_o         HI/LO are updated at the end of this cycle
//   hi_o, lo_o      HI (remainder / product high), LO (quotient / product low)
module ex_hilo_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start_i,
  input  logic             mul_start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] hilo_wdata_i,
  output logic             stallreq_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [2:0] {StIdle, StDivZero, StBusy, StMul, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder / product high
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifting into quotient / product low
  logic [WIDTH-1:0] dvs_q, dvs_d;   // |divisor| or multiplier
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             mul_go;
  logic [WIDTH-1:0] opa_abs, opb_abs;
  logic [WIDTH:0]   rem_sh, diff;

`ifdef EX_HILO_MUL_EN
  logic                 sgn_q, sgn_d;
  logic [2*WIDTH-1:0]   mul_a, mul_b, prod;

  assign mul_go = mul_start_i;
  // Sign- or zero-extend to 2*WIDTH; the truncated product is then correct for both.
  assign mul_a  = sgn_q ? {{WIDTH{quo_q[WIDTH-1]}}, quo_q} : {{WIDTH{1'b0}}, quo_q};
  assign mul_b  = sgn_q ? {{WIDTH{dvs_q[WIDTH-1]}}, dvs_q} : {{WIDTH{1'b0}}, dvs_q};
  assign prod   = mul_a * mul_b;
`else
  logic unused_mul_start;

  assign mul_go           = 1'b0;
  assign unused_mul_start = mul_start_i;
`endif

  assign opa_abs = (signed_i && opa_i[WIDTH-1]) ? (~opa_i + WIDTH'(1)) : opa_i;
  assign opb_abs = (signed_i && opb_i[WIDTH-1]) ? (~opb_i + WIDTH'(1)) : opb_i;

  // Shift {rem,quo} left by one; the extra top bit keeps the trial subtract exact.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (annul_i) begin
      // Annul cancels anything in flight and also suppresses a start in IDLE.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (div_start_i) begin
            state_d = (opb_i == '0) ? StDivZero : StBusy;
          end else if (mul_go) begin
            state_d = StMul;
          end
        end
        StDivZero: state_d = StDone;
        StBusy:    if (cnt_q == CntW'(WIDTH - 1)) state_d = StDone;
        StMul:     state_d = StDone;
        StDone:    state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    stallreq_o = ((state_q == StIdle) && (div_start_i || mul_go)) ||
                 (state_q == StBusy) || (state_q == StDivZero) || (state_q == StMul);
    ready_o    = (state_q == StDone) && !annul_i;
  end

  // Datapath next-state
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef EX_HILO_MUL_EN
    sgn_d     = sgn_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (hi_we_i) hi_d = hilo_wdata_i;
        if (lo_we_i) lo_d = hilo_wdata_i;
        if (div_start_i && !annul_i) begin
          cnt_d = '0;
          dvs_d = opb_abs;
          if (opb_i == '0) begin
            // Divide by zero: result is quotient 0, remainder = raw dividend.
            rem_d     = opa_i;
            quo_d     = '0;
            quo_neg_d = 1'b0;
            rem_neg_d = 1'b0;
          end else begin
            rem_d     = '0;
            quo_d     = opa_abs;
            quo_neg_d = signed_i && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
            rem_neg_d = signed_i && opa_i[WIDTH-1];
          end
        end else if (mul_go && !annul_i) begin
          quo_d     = opa_i;
          dvs_d     = opb_i;
          quo_neg_d = 1'b0;
          rem_neg_d = 1'b0;
`ifdef EX_HILO_MUL_EN
          sgn_d     = signed_i;
`endif
        end
      end
      StBusy: begin
        if (diff[WIDTH]) begin
          rem_d = rem_sh[WIDTH-1:0];
        end else begin
          rem_d = diff[WIDTH-1:0];
        end
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q + CntW'(1);
      end
`ifdef EX_HILO_MUL_EN
      StMul: begin
        {rem_d, quo_d} = prod;
      end
`endif
      StDone: begin
        // Result has priority over a same-cycle MTHI/MTLO.
        if (!annul_i) begin
          hi_d = rem_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
          lo_d = quo_neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

`ifdef EX_HILO_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q <= 1'b0;
    end else begin
      sgn_q <= sgn_d;
    end
  end
`endif

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_hilo_div.sv
module tb_ex_hilo_div;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        mul_start;
  logic        sgn;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        annul;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        stallreq;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] hi_ref = '0;
  logic [31:0] lo_ref = '0;

  // Expected {HI, LO} for each operation that should complete.
  logic [63:0] exp_q[$];

  ex_hilo_div dut (
    .clk          (clk),
    .rst          (rst),
    .div_start_i  (div_start),
    .mul_start_i  (mul_start),
    .signed_i     (sgn),
    .opa_i        (opa),
    .opb_i        (opb),
    .annul_i      (annul),
    .hi_we_i      (hi_we),
    .lo_we_i      (lo_we),
    .hilo_wdata_i (wdata),
    .stallreq_o   (stallreq),
    .ready_o      (ready),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: MIPS DIV/DIVU semantics with truncating division.
  function automatic void div_model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'd0;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    longint sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return 64'(ua * ub);
  endfunction

  // Monitor: whenever ready is presented, HI/LO after that edge must match the queue head.
  always begin
    logic [63:0] e;
    @(negedge clk);
    if (ready) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("hi_result", hi, e[63:32]);
        check("lo_result", lo, e[31:0]);
      end
    end
  end

  // Issue a divide and check latency / stall. mid_we > 0 drives MTHI during busy cycle mid_we;
  // collide drives MTLO during the ready cycle.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int mid_we, input bit collide);
    logic [31:0] eq, er;
    int  n;
    bit  seen, stall_ok;
    div_model(a, b, s, eq, er);
    exp_q.push_back({er, eq});
    @(negedge clk);
    div_start = 1'b1; opa = a; opb = b; sgn = s;
    #1;
    check("stall_on_start", stallreq, 1'b1);
    @(posedge clk);
    #1;
    div_start = 1'b0; opa = $urandom; opb = $urandom; sgn = $urandom_range(0, 1);
    n = 0; seen = 0; stall_ok = 1;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (mid_we > 0 && n == mid_we + 1) begin
        hi_we = 1'b0;
        check("mthi_busy_dropped", hi, hi_ref);
      end
      if (ready) seen = 1;
      else if (!stallreq) stall_ok = 0;
      if (mid_we > 0 && n == mid_we && !seen) begin
        hi_we = 1'b1; wdata = $urandom;
      end
    end
    check("ready_latency", n, (b == 32'd0) ? 2 : 33);
    check("stall_while_busy", stall_ok, 1'b1);
    check("stall_low_in_done", stallreq, 1'b0);
    if (!seen) begin
      void'(exp_q.pop_front());
    end else if (collide) begin
      lo_we = 1'b1; wdata = $urandom;
    end
    @(posedge clk);
    #2;
    lo_we = 1'b0;
    hi_ref = er;
    lo_ref = eq;
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    bit saw = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ready) saw = 1;
    end
    check(name, saw, 1'b0);
  endtask

  initial begin
    logic [31:0] a, b;
    rst = 1'b1; div_start = 0; mul_start = 0; sgn = 0; opa = 0; opb = 0;
    annul = 0; hi_we = 0; lo_we = 0; wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_stall", stallreq, 1'b0);
    check("reset_ready", ready, 1'b0);
    rst = 1'b0;

    // Directed divides
    run_div(32'd100, 32'd7, 1'b0, 0, 0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, 0);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, 0, 0);
    run_div(32'd5, 32'd0, 1'b0, 0, 0);
    run_div(32'hFFFFFFF0, 32'd0, 1'b1, 0, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 0);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 0, 0);

    // MTHI/MTLO in IDLE
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'h1234);
    hi_ref = 32'h1234;
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'hABCD;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("mtlo_idle", lo, 32'hABCD);
    lo_ref = 32'hABCD;

    // MTHI during BUSY is dropped; MTLO in DONE loses to the result
    run_div(32'd200, 32'd3, 1'b0, 5, 1);

    // Annul mid-divide
    @(negedge clk);
    div_start = 1'b1; opa = 32'd100; opb = 32'd7; sgn = 1'b0;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    check("annul_stall_low", stallreq, 1'b0);
    check("annul_hi_kept", hi, hi_ref);
    check("annul_lo_kept", lo, lo_ref);
    expect_quiet(40, "annul_no_ready");
    run_div(32'd100, 32'd7, 1'b0, 0, 0);

    // Reset during BUSY
    @(negedge clk);
    div_start = 1'b1; opa = 32'd1000; opb = 32'd9; sgn = 1'b0;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy_hi", hi, 32'd0);
    check("rst_busy_lo", lo, 32'd0);
    check("rst_busy_stall", stallreq, 1'b0);
    hi_ref = '0; lo_ref = '0;
    expect_quiet(40, "rst_no_ready");

    // Multiply
`ifdef EX_HILO_MUL_EN
    for (int k = 0; k < 2; k++) begin
      int n;
      bit seen;
      exp_q.push_back(mul_model(32'hFFFFFFFF, 32'd2, k == 0));
      @(negedge clk);
      mul_start = 1'b1; opa = 32'hFFFFFFFF; opb = 32'd2; sgn = (k == 0);
      #1;
      check("mul_stall_on_start", stallreq, 1'b1);
      @(posedge clk);
      #1;
      mul_start = 1'b0;
      n = 0; seen = 0;
      while (!seen && n < 20) begin
        @(negedge clk);
        n++;
        if (ready) seen = 1;
      end
      check("mul_latency", n, 2);
      if (!seen) void'(exp_q.pop_front());
      @(posedge clk);
      #2;
    end
`else
    @(negedge clk);
    mul_start = 1'b1; opa = 32'hFFFFFFFF; opb = 32'd2; sgn = 1'b1;
    #1;
    check("mul_ignored_no_stall", stallreq, 1'b0);
    @(posedge clk);
    #1;
    mul_start = 1'b0;
    expect_quiet(5, "mul_ignored_no_ready");
    check("mul_ignored_hi", hi, hi_ref);
    check("mul_ignored_lo", lo, lo_ref);
`endif

    // Randomized divides
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = $urandom;
        default: b = 32'hFFFFFFFF - $urandom_range(0, 7);
      endcase
      run_div(a, b, 1'(($urandom_range(0, 1))), 0, 0);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
